// File: rtl/fma16_pkg.sv
// Shared types and constants for the fma16 request arbiter.
package fma16_pkg;

    // Operation control bits carried alongside the operands.
    typedef struct packed {
        logic mul;
        logic add;
        logic negp;
        logic negz;
    } fma_op_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

    // Bit positions inside the 4-bit {invalid,overflow,underflow,inexact} flag word.
    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    localparam logic [15:0] QNAN16 = 16'h7E00;
    localparam logic [1:0]  RM_RNE = 2'b00;

    // A timed-out op reports a quiet NaN with only the invalid flag raised.
    localparam logic [3:0] TIMEOUT_FLAGS = 4'(1) << FLAG_INVALID;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] idx,
    output logic                    any
);
    localparam int IW = $clog2(NREQ);

    logic [IW:0] cand;

    // Walk the requesters starting at ptr; the first hit wins.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
            if (!any && req[cand[IW-1:0]]) begin
                any = 1'b1;
                idx = cand[IW-1:0];
            end
        end
        if (any) gnt[idx] = 1'b1;
    end

endmodule

// File: rtl/fma16_arb.sv
// Round-robin front end sharing one multi-cycle fma16 datapath between NREQ clients.
module fma16_arb
    import fma16_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*16-1:0]      req_x,
    input  logic [NREQ*16-1:0]      req_y,
    input  logic [NREQ*16-1:0]      req_z,
    input  logic [NREQ*4-1:0]       req_op,
    input  logic [1:0]              rm,
    output logic                    fma_start,
    output logic [15:0]             fma_x,
    output logic [15:0]             fma_y,
    output logic [15:0]             fma_z,
    output logic [3:0]              fma_op,
    output logic [1:0]              fma_rm,
    input  logic                    fma_done,
    input  logic [15:0]             fma_result,
    input  logic [3:0]              fma_flags,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [15:0]             rsp_result,
    output logic [3:0]              rsp_flags,
    output logic                    rsp_err,
    output logic [NREQ*4-1:0]       flags_acc,
    input  logic [NREQ-1:0]         flags_clr
);
    localparam int IW = $clog2(NREQ);

    arb_state_t             state, state_n;
    logic [NREQ-1:0]        gnt;
    logic [IW-1:0]          gidx, ptr, id_q;
    logic                   any, accept, hs, expire;
    logic [7:0]             cnt;
    fma_op_t                op_q;
    logic [NREQ-1:0][3:0]   acc;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req (req_valid),
        .ptr (ptr),
        .gnt (gnt),
        .idx (gidx),
        .any (any)
    );

    // Counter value is the number of completed WAIT cycles minus one, so the
    // forced response lands TIMEOUT cycles after the start pulse (at least one
    // WAIT cycle is always spent, even for TIMEOUT == 1).
    assign expire    = ({1'b0, cnt} + 9'd1) >= 9'(TIMEOUT - 1);
    assign rsp_valid = (state == RESP);
    assign rsp_id    = id_q;
    assign fma_op    = op_q;
    assign flags_acc = acc;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    // Next state plus the accept/start/handshake strobes. Accept is masked by
    // reset so no grant leaks out while the block is held in reset.
    always_comb begin
        state_n   = state;
        req_ready = '0;
        fma_start = 1'b0;
        accept    = 1'b0;
        hs        = 1'b0;
        case (state)
            IDLE: if (any && reset_n) begin
                req_ready = gnt;
                accept    = 1'b1;
                state_n   = ISSUE;
            end
            ISSUE: begin
                fma_start = 1'b1;
                state_n   = WAIT;
            end
            WAIT: if (fma_done || expire) state_n = RESP;
            RESP: if (rsp_ready) begin
                hs      = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Operand capture, wait counter, response latch and rr pointer update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fma_x      <= '0;
            fma_y      <= '0;
            fma_z      <= '0;
            op_q       <= '0;
            fma_rm     <= RM_RNE;
            id_q       <= '0;
            ptr        <= '0;
            cnt        <= '0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            if (accept) begin
                fma_x  <= req_x[16*gidx +: 16];
                fma_y  <= req_y[16*gidx +: 16];
                fma_z  <= req_z[16*gidx +: 16];
                op_q   <= fma_op_t'(req_op[4*gidx +: 4]);
                fma_rm <= rm;
                id_q   <= gidx;
            end
            if (state == ISSUE)     cnt <= '0;
            else if (state == WAIT) cnt <= cnt + 8'd1;
            if (state == WAIT) begin
                if (fma_done) begin
                    rsp_result <= fma_result;
                    rsp_flags  <= fma_flags;
                    rsp_err    <= 1'b0;
                end else if (expire) begin
                    rsp_result <= QNAN16;
                    rsp_flags  <= TIMEOUT_FLAGS;
                    rsp_err    <= 1'b1;
                end
            end
            if (hs) ptr <= (id_q == IW'(NREQ - 1)) ? '0 : id_q + IW'(1);
        end
    end

    // Per-requester sticky flags; a clear in the same cycle beats the set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (flags_clr[i])                 acc[i] <= '0;
                else if (hs && id_q == IW'(i))    acc[i] <= acc[i] | rsp_flags;
            end
        end
    end

endmodule
